// File: rtl/decode_pkg.sv
// decode_pkg: opcode encodings and control-bundle bit positions shared by the
// decode stage, its register file and the ID/EX interface.
package decode_pkg;

    // Primary opcodes (instr[31:26]) recognised by the decoder.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // ex_ctrl layout, MSB first: {wen, mem_rd, mem_wr, branch, use_imm, illegal}.
    localparam int CTRL_W       = 6;
    localparam int CTRL_ILLEGAL = 0;
    localparam int CTRL_USE_IMM = 1;
    localparam int CTRL_BRANCH  = 2;
    localparam int CTRL_MEM_WR  = 3;
    localparam int CTRL_MEM_RD  = 4;
    localparam int CTRL_WEN     = 5;

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch->decode offer and decode->execute ID/EX bundle.
// Handshake: on each rising clock edge a beat moves when valid && ready are
// both high; the producer holds valid and its payload stable until that edge,
// and valid never waits on ready.
interface decode_if
    import decode_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int REG_AW = $clog2(NREGS);

    // Fetch side
    logic              if_valid;
    logic              if_ready;
    logic [PC_W-1:0]   if_pc;
    logic [31:0]       if_instr;

    // Execute side
    logic              ex_valid;
    logic              ex_ready;
    logic [PC_W-1:0]   ex_pc;
    logic [5:0]        ex_opcode;
    logic [5:0]        ex_funct;
    logic [XLEN-1:0]   ex_rs_val;
    logic [XLEN-1:0]   ex_rt_val;
    logic [XLEN-1:0]   ex_imm;
    logic [REG_AW-1:0] ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    // Environment view: drives fetch offers and execute acceptance.
    modport master (
        output if_valid, if_pc, if_instr, ex_ready,
        input  if_ready, ex_valid, ex_pc, ex_opcode, ex_funct,
               ex_rs_val, ex_rt_val, ex_imm, ex_rd, ex_ctrl
    );

    // Decode-stage view.
    modport slave (
        input  if_valid, if_pc, if_instr, ex_ready,
        output if_ready, ex_valid, ex_pc, ex_opcode, ex_funct,
               ex_rs_val, ex_rt_val, ex_imm, ex_rd, ex_ctrl
    );

endinterface

// File: rtl/decode_regfile.sv
// decode_regfile: NREGS x XLEN register file, two combinational read ports and
// one write port. Register 0 is hard-wired to zero; a write to the address being
// read in the same cycle is forwarded to the read port.
module decode_regfile
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int REG_AW = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [REG_AW-1:0] wr_addr_i,
    input  logic [XLEN-1:0]   wr_data_i,
    input  logic [REG_AW-1:0] rd0_addr_i,
    output logic [XLEN-1:0]   rd0_data_o,
    input  logic [REG_AW-1:0] rd1_addr_i,
    output logic [XLEN-1:0]   rd1_data_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Storage: cleared by reset, register 0 is never written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port 0 with zero register and write-through bypass.
    always_comb begin
        rd0_data_o = regs_q[rd0_addr_i];
        if (rd0_addr_i == '0) begin
            rd0_data_o = '0;
        end else if (wr_en_i && (wr_addr_i == rd0_addr_i)) begin
            rd0_data_o = wr_data_i;
        end
    end

    // Read port 1 with zero register and write-through bypass.
    always_comb begin
        rd1_data_o = regs_q[rd1_addr_i];
        if (rd1_addr_i == '0) begin
            rd1_data_o = '0;
        end else if (wr_en_i && (wr_addr_i == rd1_addr_i)) begin
            rd1_data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS-style ID stage. Decodes the offered instruction, reads
// operands with writeback bypass, stalls on load-use and presents a registered
// ID/EX bundle. Optional DECODE_PERF_CNT_EN adds issue/stall counters.
module decode_stage
    import decode_pkg::*;
#(
    parameter int  PC_W   = 32,
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    decode_if.slave           bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stalls
`endif
);

    logic [31:0]       instr;
    logic [REG_AW-1:0] rs_a, rt_a, rd_a;
    logic [XLEN-1:0]   rs_val_d, rt_val_d, imm_d;
    logic [REG_AW-1:0] dest_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              hazard, transfer;

    logic              ex_valid_q;
    logic [PC_W-1:0]   ex_pc_q;
    logic [5:0]        ex_opcode_q, ex_funct_q;
    logic [XLEN-1:0]   ex_rs_val_q, ex_rt_val_q, ex_imm_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic [CTRL_W-1:0] ex_ctrl_q;

    // Register fields keep only the low REG_AW bits when NREGS < 32.
    assign instr = bus.if_instr;
    assign rs_a  = instr[21 +: REG_AW];
    assign rt_a  = instr[16 +: REG_AW];
    assign rd_a  = instr[11 +: REG_AW];
    assign imm_d = {{(XLEN-16){instr[15]}}, instr[15:0]};

    decode_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .REG_AW(REG_AW)
    ) u_regfile (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (wb_en),
        .wr_addr_i (wb_addr),
        .wr_data_i (wb_data),
        .rd0_addr_i(rs_a),
        .rd0_data_o(rs_val_d),
        .rd1_addr_i(rt_a),
        .rd1_data_o(rt_val_d)
    );

    // Opcode decode into control bits and destination register.
    always_comb begin
        ctrl_d = '0;
        dest_d = '0;
        unique case (instr[31:26])
            OP_RTYPE: begin
                ctrl_d[CTRL_WEN] = 1'b1;
                dest_d           = rd_a;
            end
            OP_ADDI: begin
                ctrl_d[CTRL_WEN]     = 1'b1;
                ctrl_d[CTRL_USE_IMM] = 1'b1;
                dest_d               = rt_a;
            end
            OP_LW: begin
                ctrl_d[CTRL_WEN]     = 1'b1;
                ctrl_d[CTRL_MEM_RD]  = 1'b1;
                ctrl_d[CTRL_USE_IMM] = 1'b1;
                dest_d               = rt_a;
            end
            OP_SW: begin
                ctrl_d[CTRL_MEM_WR]  = 1'b1;
                ctrl_d[CTRL_USE_IMM] = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d[CTRL_BRANCH] = 1'b1;
            end
            default: begin
                ctrl_d[CTRL_ILLEGAL] = 1'b1;
            end
        endcase
        // Writes to register 0 are architecturally dead.
        if (dest_d == '0) begin
            ctrl_d[CTRL_WEN] = 1'b0;
        end
    end

    // Load-use: the load in ID/EX has not produced its data yet.
    assign hazard = ex_valid_q && ex_ctrl_q[CTRL_MEM_RD] && (ex_rd_q != '0) &&
                    ((ex_rd_q == rs_a) || (ex_rd_q == rt_a));

    // Flush always drains the offer; otherwise accept when ID/EX frees up.
    assign bus.if_ready = !reset && (flush || ((!ex_valid_q || bus.ex_ready) && !hazard));
    assign transfer     = bus.if_valid && bus.if_ready && !flush;

    // ID/EX register: flush empties it, a transfer loads it, consumption
    // without a new instruction (including a load-use hold) leaves a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= '0;
            ex_opcode_q <= '0;
            ex_funct_q  <= '0;
            ex_rs_val_q <= '0;
            ex_rt_val_q <= '0;
            ex_imm_q    <= '0;
            ex_rd_q     <= '0;
            ex_ctrl_q   <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (transfer) begin
            ex_valid_q  <= 1'b1;
            ex_pc_q     <= bus.if_pc;
            ex_opcode_q <= instr[31:26];
            ex_funct_q  <= instr[5:0];
            ex_rs_val_q <= rs_val_d;
            ex_rt_val_q <= rt_val_d;
            ex_imm_q    <= imm_d;
            ex_rd_q     <= dest_d;
            ex_ctrl_q   <= ctrl_d;
        end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_pc     = ex_pc_q;
    assign bus.ex_opcode = ex_opcode_q;
    assign bus.ex_funct  = ex_funct_q;
    assign bus.ex_rs_val = ex_rs_val_q;
    assign bus.ex_rt_val = ex_rt_val_q;
    assign bus.ex_imm    = ex_imm_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_ctrl   = ex_ctrl_q;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_stalls_q;

    // Free-running issue and stall counters, wrapping at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_issued_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (transfer) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if (bus.if_valid && !bus.if_ready && !flush) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage (build with or without
// DECODE_PERF_CNT_EN).
module tb_decode_stage;
    import decode_pkg::*;

    localparam int PC_W   = 32;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0]       perf_issued;
    logic [31:0]       perf_stalls;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    decode_if #(.PC_W(PC_W), .XLEN(XLEN), .NREGS(NREGS)) bus ();

    decode_stage #(.PC_W(PC_W), .XLEN(XLEN), .NREGS(NREGS)) dut (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .wb_en  (wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .bus    (bus)
`ifdef DECODE_PERF_CNT_EN
        ,
        .perf_issued(perf_issued),
        .perf_stalls(perf_stalls)
`endif
    );

    // Clock and reset
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Checker
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        bus.if_instr = instr;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0;
    endtask

    task automatic check_bundle(input string tag, input logic [31:0] pc, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [5:0] ctrl);
        check({tag, ".valid"}, bus.ex_valid, 1'b1);
        check({tag, ".pc"}, bus.ex_pc, pc);
        check({tag, ".rs"}, bus.ex_rs_val, rs);
        check({tag, ".rt"}, bus.ex_rt_val, rt);
        check({tag, ".imm"}, bus.ex_imm, imm);
        check({tag, ".rd"}, bus.ex_rd, rd);
        check({tag, ".ctrl"}, bus.ex_ctrl, ctrl);
    endtask

    // Directed sequence
    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        wb_en        = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        bus.if_valid = 1'b0;
        bus.if_pc    = '0;
        bus.if_instr = '0;
        bus.ex_ready = 1'b1;
        tick();
        tick();
        check("rst.valid", bus.ex_valid, 1'b0);
        check("rst.pc", bus.ex_pc, 32'h0);
        check("rst.ctrl", bus.ex_ctrl, 6'h00);
        check("rst.ready", bus.if_ready, 1'b0);

        reset = 1'b0;
        #1;
        check("post_rst.ready", bus.if_ready, 1'b1);

        // Preload x5, x2, x3 through the writeback port.
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234; tick();
        wb_addr = 5'd2; wb_data = 32'h0000_2222; tick();
        wb_addr = 5'd3; wb_data = 32'h0000_3333; tick();
        wb_en = 1'b0;

        // ADDI x6, x5, -1
        offer(32'h100, 32'h20A6_FFFF);
        #1 check("addi.ready", bus.if_ready, 1'b1);
        tick();
        idle();
        check_bundle("addi", 32'h100, 32'h1234, 32'h0, 32'hFFFF_FFFF, 5'd6, 6'h22);
        check("addi.opcode", bus.ex_opcode, 6'h08);
        check("addi.funct", bus.ex_funct, 6'h3F);

        // LW x3, 0(x0) followed by ADD x4, x3, x2: one bubble.
        offer(32'h104, 32'h8C03_0000);
        tick();
        check_bundle("lw", 32'h104, 32'h0, 32'h3333, 32'h0, 5'd3, 6'h32);
        offer(32'h108, 32'h0062_2020);
        #1 check("hazard.ready", bus.if_ready, 1'b0);
        tick();
        check("bubble.valid", bus.ex_valid, 1'b0);
        check("bubble.ready", bus.if_ready, 1'b1);
        tick();
        idle();
        check_bundle("add", 32'h108, 32'h3333, 32'h2222, 32'h2020, 5'd4, 6'h20);
        check("add.funct", bus.ex_funct, 6'h20);

        // Backpressure for three cycles with SW offered.
        bus.ex_ready = 1'b0;
        offer(32'h10C, 32'hAC22_0004);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp.ready", bus.if_ready, 1'b0);
            tick();
            check("bp.valid", bus.ex_valid, 1'b1);
            check("bp.pc", bus.ex_pc, 32'h108);
            check("bp.rs", bus.ex_rs_val, 32'h3333);
            check("bp.ctrl", bus.ex_ctrl, 6'h20);
        end
        bus.ex_ready = 1'b1;
        #1 check("bp_rel.ready", bus.if_ready, 1'b1);
        tick();
        idle();
        check_bundle("sw", 32'h10C, 32'h0, 32'h2222, 32'h4, 5'd0, 6'h0A);

        // Same-cycle writeback bypass to rs.
        offer(32'h110, 32'h00E0_4021);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_en = 1'b0;
        check_bundle("byp", 32'h110, 32'hDEAD_BEEF, 32'h0, 32'h4021, 5'd8, 6'h20);

        // Write to x0 is ignored, including the bypass path.
        offer(32'h114, 32'h0000_4820);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        wb_en = 1'b0;
        check_bundle("r0_wb", 32'h114, 32'h0, 32'h0, 32'h4820, 5'd9, 6'h20);

        // Later read of x0, destination x0 suppresses wen.
        offer(32'h118, 32'h0000_0020);
        tick();
        check_bundle("r0_rd", 32'h118, 32'h0, 32'h0, 32'h20, 5'd0, 6'h00);

        // Illegal opcode 0x3F.
        offer(32'h11C, 32'hFC00_5800);
        tick();
        check_bundle("ill", 32'h11C, 32'h0, 32'h0, 32'h5800, 5'd0, 6'h01);
        check("ill.opcode", bus.ex_opcode, 6'h3F);

        // BEQ x1, x2, 3
        offer(32'h120, 32'h1022_0003);
        tick();
        check_bundle("beq", 32'h120, 32'h0, 32'h2222, 32'h3, 5'd0, 6'h04);

        // Flush during a valid offer.
        offer(32'h200, 32'h20A6_FFFF);
        flush = 1'b1;
        #1 check("flush.ready", bus.if_ready, 1'b1);
        tick();
        flush = 1'b0;
        idle();
        check("flush.valid", bus.ex_valid, 1'b0);
        check("flush.pc", bus.ex_pc, 32'h120);
        tick();
        check("flush.valid2", bus.ex_valid, 1'b0);

        // Fill ID/EX, then reset between edges.
        offer(32'h300, 32'h20A6_FFFF);
        tick();
        idle();
        check("pre_arst.valid", bus.ex_valid, 1'b1);
        check("pre_arst.pc", bus.ex_pc, 32'h300);
`ifdef DECODE_PERF_CNT_EN
        check("perf.issued", perf_issued, 32'd10);
        check("perf.stalls", perf_stalls, 32'd4);
`endif
        #2 reset = 1'b1;
        #1;
        check("arst.valid", bus.ex_valid, 1'b0);
        check("arst.pc", bus.ex_pc, 32'h0);
        check("arst.ready", bus.if_ready, 1'b0);
`ifdef DECODE_PERF_CNT_EN
        check("arst.issued", perf_issued, 32'd0);
        check("arst.stalls", perf_stalls, 32'd0);
`endif
        tick();
        reset = 1'b0;

        // Register file was cleared: x5 reads 0.
        offer(32'h400, 32'h00A0_0820);
        tick();
        idle();
        check_bundle("post_arst", 32'h400, 32'h0, 32'h0, 32'h0820, 5'd1, 6'h20);

        // Report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor to the fixed-width IF/ID→ID/EX decoder.
- Accepts {pc, instr} from fetch with a valid/ready handshake and decodes a MIPS-style 32-bit instruction.
- Reads an internal register file with same-cycle writeback bypass and detects load-use hazards.
- Presents a registered ID/EX bundle to execute. Supports stall, bubble insertion and flush.

Parameters:
PC_W, 32, program counter width
XLEN, 32, register/data width
NREGS, 32, architectural registers (power of 2, ≤32); REG_AW = clog2(NREGS)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
if_valid  in  1  fetch offers instruction
if_ready  out  1  stage accepts this cycle
if_pc  in  PC_W  instruction address
if_instr  in  32  instruction word
flush  in  1  discard in-flight and offered instruction
wb_en  in  1  register writeback strobe
wb_addr  in  REG_AW  writeback register
wb_data  in  XLEN  writeback value
ex_valid  out  1  ID/EX bundle valid
ex_ready  in  1  execute consumes bundle
ex_pc  out  PC_W  registered pc
ex_opcode  out  6  instr[31:26]
ex_funct  out  6  instr[5:0]
ex_rs_val  out  XLEN  rs operand
ex_rt_val  out  XLEN  rt operand
ex_imm  out  XLEN  sign-extended instr[15:0]
ex_rd  out  REG_AW  destination register
ex_ctrl  out  6  {wen, mem_rd, mem_wr, branch, use_imm, illegal}

Behaviour:
- Reset (async, active-high): all ex_* outputs = 0, and all registers in the file = 0.
- if_ready = !reset && (flush || ((!ex_valid || ex_ready) && !hazard)).
- Transfer occurs when if_valid && if_ready && !flush. The bundle is registered on that edge, giving 1-cycle latency.
- Field extraction: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11]. Each is truncated to REG_AW bits.
- Opcode decode:
  - 0x00 R-type: wen=1, dest=rd.
  - 0x08 ADDI: wen, use_imm, dest=rt.
  - 0x23 LW: wen, mem_rd, use_imm, dest=rt.
  - 0x2B SW: mem_wr, use_imm.
  - 0x04 BEQ: branch.
  - Any other opcode: illegal=1, all other ctrl bits=0, ex_rd=0.
- If the destination is register 0, wen is forced to 0.
- Register file: reg0 always reads 0, and writes to reg0 are ignored. When wb_en && wb_addr==read addr && addr≠0, the read returns wb_data in the same cycle (write-through bypass).
- Hazard: hazard = ex_valid && ex_ctrl.mem_rd && ex_rd≠0 && (ex_rd==rs || ex_rd==rt) for the offered if_instr.
  - On hazard with ex_ready=1, the output register loads a bubble (ex_valid=0) and fetch is held.
  - The held instruction transfers on the next cycle.
- Backpressure: when ex_valid && !ex_ready, every ex_* output holds stable and if_ready=0.
- Flush (synchronous): at the next edge ex_valid=0. The offered instruction is consumed and dropped (if_ready=1). Flush takes priority over hazard and backpressure.
- Writeback is independent of the handshake and happens even during flush or stall.
- A reset asserted mid-transfer clears ex_valid immediately and discards the pending transfer.

Optional Feature:
- Macro DECODE_PERF_CNT_EN.
- When defined, two outputs are added:
  - perf_issued [31:0]: increments on each transfer.
  - perf_stalls [31:0]: increments on each cycle with if_valid && !if_ready && !flush.
- Both counters wrap at 2^32 and are cleared by reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package decode_pkg holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ;
  - ctrl bit index constants CTRL_WEN..CTRL_ILLEGAL and CTRL_W=6.
- Sub-module decode_regfile: NREGS×XLEN, two async read ports, one write port, with the bypass and reg0 rules. It is instantiated once in decode_stage.

Test Plan:
- Reset, then wb x5=0x1234, then offer ADDI rt=6 rs=5 imm=0xFFFF (instr 0x20A6FFFF) → next cycle: ex_valid=1, rs_val=0x1234, imm=0xFFFFFFFF, rd=6, ctrl wen|use_imm.
- LW rt=3 (0x8C030000), then ADD rd=4 rs=3 rt=2 with ex_ready=1 → one bubble cycle (ex_valid=0, if_ready=0); ADD then issues on the following cycle.
- Hold ex_ready=0 for 3 cycles with a valid bundle → ex_* outputs stable and if_ready=0 throughout; the next instruction issues 1 cycle after ex_ready rises.
- wb_en with wb_addr=7, wb_data=0xDEADBEEF in the same cycle as offering R-type reading rs=7 → ex_rs_val=0xDEADBEEF. A write to reg0 → later reads of reg0 return 0.
- Opcode 0x3F → illegal=1, wen=0, ex_rd=0. Flush during a valid offer → ex_valid=0 next cycle and the instruction is not issued.
- Assert reset asynchronously between edges while ex_valid=1 → ex_valid falls without a clock edge. With DECODE_PERF_CNT_EN, the counters read 0.
